// File: rtl/mips_pkg.sv
// ----------------------------------------------------------------------------
// mips_pkg : shared states, opcodes and select encodings for the sequencer
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

package mips_pkg;

  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    MEM       = 3'd3,
    WRITEBACK = 3'd4
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] ALU_ADD = 6'h20;
  localparam logic [5:0] ALU_SUB = 6'h22;

  localparam logic [1:0] PC_SRC_SEQ = 2'd0;
  localparam logic [1:0] PC_SRC_BR  = 2'd1;
  localparam logic [1:0] PC_SRC_JMP = 2'd2;

  function automatic logic is_supported(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_J)  || (op == OP_BEQ) ||
           (op == OP_ADDI)  || (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mips_multicycle_sequencer_if.sv
// ----------------------------------------------------------------------------
// mips_multicycle_sequencer_if : control/handshake bundle between sequencer
//                                and datapath/memories
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

interface mips_multicycle_sequencer_if #(
  parameter int CNT_W = 32
);
  logic [5:0]       opcode;
  logic [5:0]       funct;
  logic             alu_zero;
  logic             imem_ack;
  logic             dmem_ack;
  logic             imem_req;
  logic             dmem_req;
  logic             dmem_we;
  logic             ir_write_en;
  logic             pc_write_en;
  logic [1:0]       pc_src;
  logic             alu_src_b;
  logic [5:0]       alu_op;
  logic             reg_write_en;
  logic             reg_dst;
  logic             mem_to_reg;
  logic             illegal_instr;
  logic             bus_error;
  logic [CNT_W-1:0] instr_count;

  modport master (
    input  opcode, funct, alu_zero, imem_ack, dmem_ack,
    output imem_req, dmem_req, dmem_we, ir_write_en, pc_write_en, pc_src,
           alu_src_b, alu_op, reg_write_en, reg_dst, mem_to_reg,
           illegal_instr, bus_error, instr_count
  );

  modport slave (
    output opcode, funct, alu_zero, imem_ack, dmem_ack,
    input  imem_req, dmem_req, dmem_we, ir_write_en, pc_write_en, pc_src,
           alu_src_b, alu_op, reg_write_en, reg_dst, mem_to_reg,
           illegal_instr, bus_error, instr_count
  );
endinterface

`default_nettype wire

// File: rtl/mem_timeout_counter.sv
// ----------------------------------------------------------------------------
// mem_timeout_counter : counts unacknowledged request cycles, flags the
//                       timeout and holds a one-cycle backoff afterwards
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module mem_timeout_counter #(
  parameter int MEM_TIMEOUT = 16
) (
  input  wire logic clk,
  input  wire logic reset,
  input  wire logic clear_i,
  input  wire logic en_i,
  output logic      hit_o,
  output logic      backoff_o
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] LAST    = CW'(MEM_TIMEOUT - 1);
  localparam logic [CW-1:0] BACKOFF = CW'(MEM_TIMEOUT);

  logic [CW-1:0] cnt_q, cnt_d;

  // The value MEM_TIMEOUT is never reached by counting, so it marks the backoff cycle.
  assign backoff_o = (cnt_q == BACKOFF);
  assign hit_o     = en_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i || backoff_o) begin
      cnt_d = '0;
    end else if (hit_o) begin
      cnt_d = BACKOFF;
    end else if (en_i) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mips_multicycle_sequencer.sv
// ----------------------------------------------------------------------------
// mips_multicycle_sequencer : multicycle control FSM for the MIPS datapath
//                             with timed-out memory handshakes
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module mips_multicycle_sequencer
  import mips_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  wire logic                    clk,
  input  wire logic                    reset,
  mips_multicycle_sequencer_if.master  seq_if
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             retire;

  logic w_imem_req, w_dmem_req;
  logic w_iack, w_dack;
  logic w_tmo_en, w_hit, w_backoff, w_clear;

  // Requests are gated by reset so every output reads 0 while reset is held.
  assign w_imem_req = reset && (state_q == FETCH) && !w_backoff;
  assign w_dmem_req = reset && (state_q == MEM);
  assign w_iack     = w_imem_req && seq_if.imem_ack;
  assign w_dack     = w_dmem_req && seq_if.dmem_ack;
  assign w_tmo_en   = (w_imem_req && !seq_if.imem_ack) ||
                      (w_dmem_req && !seq_if.dmem_ack);
  assign w_clear    = (state_d != state_q);

  mem_timeout_counter #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_tmo (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (w_clear),
    .en_i      (w_tmo_en),
    .hit_o     (w_hit),
    .backoff_o (w_backoff)
  );

  assign seq_if.imem_req    = w_imem_req;
  assign seq_if.dmem_req    = w_dmem_req;
  assign seq_if.bus_error   = w_hit;
  assign seq_if.instr_count = count_q;

  always_comb begin
    state_d              = state_q;
    retire               = 1'b0;
    seq_if.dmem_we       = 1'b0;
    seq_if.ir_write_en   = 1'b0;
    seq_if.pc_write_en   = 1'b0;
    seq_if.pc_src        = PC_SRC_SEQ;
    seq_if.alu_src_b     = 1'b0;
    seq_if.alu_op        = 6'h00;
    seq_if.reg_write_en  = 1'b0;
    seq_if.reg_dst       = 1'b0;
    seq_if.mem_to_reg    = 1'b0;
    seq_if.illegal_instr = 1'b0;
    if (reset) begin
      case (state_q)
        FETCH: begin
          if (w_iack) begin
            seq_if.ir_write_en = 1'b1;
            seq_if.pc_write_en = 1'b1;
            seq_if.pc_src      = PC_SRC_SEQ;
            state_d            = DECODE;
          end
        end
        DECODE: begin
          if (is_supported(seq_if.opcode)) begin
            state_d = EXECUTE;
          end else begin
            seq_if.illegal_instr = 1'b1;
            state_d              = FETCH;
          end
        end
        EXECUTE: begin
          state_d = FETCH;
          retire  = 1'b1;
          case (seq_if.opcode)
            OP_RTYPE: begin
              seq_if.alu_op = seq_if.funct;
              state_d       = WRITEBACK;
              retire        = 1'b0;
            end
            OP_ADDI, OP_LW, OP_SW: begin
              seq_if.alu_op    = ALU_ADD;
              seq_if.alu_src_b = 1'b1;
              state_d          = (seq_if.opcode == OP_ADDI) ? WRITEBACK : MEM;
              retire           = 1'b0;
            end
            OP_BEQ: begin
              seq_if.alu_op = ALU_SUB;
              if (seq_if.alu_zero) begin
                seq_if.pc_write_en = 1'b1;
                seq_if.pc_src      = PC_SRC_BR;
              end
            end
            OP_J: begin
              seq_if.pc_write_en = 1'b1;
              seq_if.pc_src      = PC_SRC_JMP;
            end
            default: ;
          endcase
        end
        MEM: begin
          seq_if.dmem_we = (seq_if.opcode == OP_SW);
          if (w_dack) begin
            if (seq_if.opcode == OP_LW) begin
              state_d = WRITEBACK;
            end else begin
              state_d = FETCH;
              retire  = 1'b1;
            end
          end else if (w_hit) begin
            // Abandoned access: no writeback and not counted as retired.
            state_d = FETCH;
          end
        end
        WRITEBACK: begin
          seq_if.reg_write_en = 1'b1;
          seq_if.reg_dst      = (seq_if.opcode == OP_RTYPE);
          seq_if.mem_to_reg   = (seq_if.opcode == OP_LW);
          state_d             = FETCH;
          retire              = 1'b1;
        end
        default: state_d = FETCH;
      endcase
    end
  end

  assign count_d = count_q + CNT_W'(retire);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FETCH;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

endmodule

`default_nettype wire

// File: doc/mips_multicycle_sequencer.md
Name: mips_multicycle_sequencer

Overview:
- Moore/Mealy control FSM that sequences the single shared ALU, register file and PC of the MIPS core over multiple cycles per instruction.
- Handles request/acknowledge handshakes with instruction and data memory, with a bounded timeout on each.
- Drives every datapath enable and mux select.
- Sits beside the existing control/ALU/register-file datapath and replaces the free-running pc <= pc+4 update.

Parameters:
- MEM_TIMEOUT, 16, cycles a memory request may stay unacknowledged before the bus error path is taken (min 2).
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- opcode  in  6  instr[31:26] from the datapath instruction register
- funct  in  6  instr[5:0]
- alu_zero  in  1  ALU result == 0
- imem_ack  in  1  instruction memory data valid
- dmem_ack  in  1  data memory access complete
- imem_req  out  1  fetch request
- dmem_req  out  1  data access request
- dmem_we  out  1  data write (SW)
- ir_write_en  out  1  latch instruction register
- pc_write_en  out  1  update PC
- pc_src  out  2  0=PC+4, 1=branch target, 2=jump target
- alu_src_b  out  1  0=reg_out_2, 1=sign-extended immediate
- alu_op  out  6  ALU operation code
- reg_write_en  out  1  register file write strobe
- reg_dst  out  1  1=rd, 0=rt
- mem_to_reg  out  1  1=write-back from data memory
- illegal_instr  out  1  one-cycle pulse on an unsupported opcode
- bus_error  out  1  one-cycle pulse on memory timeout
- instr_count  out  CNT_W  retired-instruction count

Behaviour:
- Supported opcodes: R=6'h00, J=6'h02, BEQ=6'h04, ADDI=6'h08, LW=6'h23, SW=6'h2B.
- ALU_ADD=6'h20, ALU_SUB=6'h22.
- Reset (reset low, async): state=FETCH, timeout counter=0, instr_count=0. All outputs 0 while reset is asserted, including imem_req.
- Outputs are decoded combinationally from state, opcode/funct and acks. Only state, the timeout counter and instr_count are registered.
- FETCH:
  - imem_req=1.
  - On imem_ack: ir_write_en=1, pc_write_en=1, pc_src=0 in the same cycle; next state DECODE.
  - Fetch latency is therefore 1 + ack delay.
- DECODE (1 cycle):
  - Unsupported opcode: illegal_instr=1, next FETCH. The PC has already advanced and instr_count is not incremented.
  - Otherwise next EXECUTE.
- EXECUTE (1 cycle):
  - R: alu_op=funct, alu_src_b=0; next WRITEBACK.
  - ADDI/LW/SW: alu_op=ALU_ADD, alu_src_b=1. ADDI goes to WRITEBACK; LW/SW go to MEM.
  - BEQ: alu_op=ALU_SUB, alu_src_b=0. If alu_zero: pc_write_en=1, pc_src=1. Next FETCH; retires.
  - J: pc_write_en=1, pc_src=2; next FETCH; retires.
- MEM:
  - dmem_req=1; dmem_we=1 iff SW.
  - On dmem_ack: LW goes to WRITEBACK; SW goes to FETCH and retires.
- WRITEBACK (1 cycle):
  - reg_write_en=1; reg_dst=1 iff R; mem_to_reg=1 iff LW.
  - Next FETCH; retires.
- Retire: instr_count increments by 1 on the transition into FETCH from EXECUTE, MEM or WRITEBACK. Wraps modulo 2^CNT_W.
- Timeout counter:
  - Clears on entry to FETCH/MEM and on any ack.
  - Increments each cycle a request is high without ack.
  - When it reaches MEM_TIMEOUT-1 with no ack: bus_error=1 that cycle and the request is dropped.
  - FETCH timeout: stay in FETCH and retry the same PC (no pc_write_en). imem_req is low for exactly one cycle before re-asserting.
  - MEM timeout: abandon the instruction, no writeback, next FETCH, not retired.
- Simultaneous ack and timeout in the same cycle: ack wins, no bus_error.
- Acks outside the matching request state are ignored.
- reg_write_en, pc_write_en and ir_write_en are never high in the same cycle, except the pc_write_en+ir_write_en pair in FETCH.

Decomposition:
- Package mips_pkg holds:
  - state_t enum {FETCH, DECODE, EXECUTE, MEM, WRITEBACK};
  - opcode constants OP_RTYPE/OP_J/OP_BEQ/OP_ADDI/OP_LW/OP_SW;
  - ALU_ADD/ALU_SUB;
  - pc_src constants PC_SRC_SEQ/PC_SRC_BR/PC_SRC_JMP.
- One sub-module, mem_timeout_counter: clear, enable, hit output, parameterised by MEM_TIMEOUT.
- Everything else stays in one FSM module.

Test Plan:
- ADDI, imem_ack 2 cycles after req:
  - imem_req high for 3 cycles; ir_write_en+pc_write_en pulse on the ack cycle.
  - reg_write_en exactly 3 cycles later with reg_dst=0.
  - instr_count=1.
- R-type funct=6'h22, immediate ack:
  - alu_op=6'h22 and alu_src_b=0 in EXECUTE.
  - reg_dst=1 in WRITEBACK; 4 cycles per instruction.
- BEQ with alu_zero=1 → pc_write_en=1, pc_src=1 in EXECUTE. BEQ with alu_zero=0 → no PC write. Both retire.
- LW with dmem_ack delayed 3 cycles → dmem_we=0, dmem_req high 4 cycles, then reg_write_en=1 with mem_to_reg=1. SW → dmem_we=1, no reg_write_en, next FETCH.
- Timeouts (MEM_TIMEOUT=4):
  - imem_ack never → bus_error pulse on the 4th req cycle, req low 1 cycle, then re-request; no pc_write_en.
  - Ack arriving on the 4th cycle → no bus_error.
- Opcode 6'h3F → illegal_instr pulse in DECODE, instr_count unchanged.
- reset low mid-MEM → all outputs 0 immediately; after release, FETCH with imem_req=1 and instr_count=0.
